// File: rtl/usr_pkg.sv
// Shared types and encodings for the universal-shift-register sequencer:
// FSM states, command shift modes and the usr mode-select codes.
package usr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_ROR  = 2'b11
    } mode_e;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    // Rotate right is a right shift whose serial input is the current LSB.
    function automatic logic [1:0] shift_sel(input mode_e mode);
        return (mode == MODE_SHL) ? USR_SHL : USR_SHR;
    endfunction

endpackage

// File: rtl/usr_seq_if.sv
// Command handshake between a command source (master) and the usr sequencer (slave).
interface usr_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [1:0]       cmd_mode;
    logic             cmd_fill;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid, cmd_load, cmd_mode, cmd_fill, cmd_data, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_mode, cmd_fill, cmd_data, cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/usr.sv
// Universal shift register: hold, shift right (r_in enters MSB),
// shift left (l_in enters LSB) or parallel load, selected by {s1,s0}.
module usr
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] b,
    input  logic             r_in,
    input  logic             l_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            case ({s1, s0})
                USR_SHR:  q_q <= {r_in, q_q[WIDTH-1:1]};
                USR_SHL:  q_q <= {q_q[WIDTH-2:0], l_in};
                USR_LOAD: q_q <= b;
                default:  q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/usr_seq.sv
// Sequencer that drives an external usr instance through optional parallel
// load, a counted run of shift/rotate cycles, and a one-cycle done pulse.
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    usr_seq_if.slave         cmd,
    input  logic [WIDTH-1:0] q_fb,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] b,
    output logic             r_in,
    output logic             l_in,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q,  mode_d;
    logic             fill_q,  fill_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    function automatic logic wants_shift(input mode_e mode, input logic [CNT_W-1:0] count);
        return (mode != MODE_NONE) && (count != '0);
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        b_d     = b_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    mode_d = mode_e'(cmd.cmd_mode);
                    fill_d = cmd.cmd_fill;
                    b_d    = cmd.cmd_data;
                    cnt_d  = cmd.cmd_count;
                    if (cmd.cmd_load) begin
                        state_d = LOAD;
                    end else if (wants_shift(mode_e'(cmd.cmd_mode), cmd.cmd_count)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                state_d = wants_shift(mode_q, cnt_q) ? SHIFT : DONE;
            end
            SHIFT: begin
                // cnt_q holds the shifts still to perform, including this one.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            LOAD:    sel_d = USR_LOAD;
            SHIFT:   sel_d = shift_sel(mode_d);
            default: sel_d = USR_HOLD;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_NONE;
            fill_q  <= 1'b0;
            b_q     <= '0;
            cnt_q   <= '0;
            sel_q   <= USR_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            ready_q <= (state_d == IDLE);
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign s1            = sel_q[1];
    assign s0            = sel_q[0];
    assign b             = b_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // Rotate right feeds the register's own LSB back into its MSB.
    assign r_in = (sel_q == USR_SHR) && ((mode_q == MODE_ROR) ? q_fb[0] : fill_q);
    assign l_in = (sel_q == USR_SHL) && fill_q;

    logic unused_fb;
    assign unused_fb = ^q_fb[WIDTH-1:1];

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq driving a usr instance: per-cycle scoreboard of select,
// serial inputs, handshake flags and register contents.
module tb_usr_seq;
    import usr_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [1:0] sel;
        logic       rin;
        logic       lin;
        logic       busy;
        logic       done;
        logic       ready;
        logic [3:0] q;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic             s1, s0, r_in, l_in, busy, done;

    obs_t       sb_q[$];
    logic [3:0] q_m;
    int         n_cmp = 0;
    int         n_err = 0;

    usr_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    usr_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_if.slave),
        .q_fb (q),
        .s1   (s1),
        .s0   (s0),
        .b    (b),
        .r_in (r_in),
        .l_in (l_in),
        .busy (busy),
        .done (done)
    );

    usr #(.WIDTH(WIDTH)) u_usr (
        .clk  (clk),
        .rst  (rst),
        .s1   (s1),
        .s0   (s0),
        .b    (b),
        .r_in (r_in),
        .l_in (l_in),
        .q    (q)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o = {s1, s0, r_in, l_in, busy, done, cmd_if.cmd_ready, q};
        return o;
    endfunction

    // Expected per-cycle trace of one command, ending with the idle cycle after done.
    function automatic void push_cmd(input logic load, input logic [1:0] mode, input logic fill,
                                     input logic [3:0] data, input logic [2:0] count);
        obs_t e;
        if (load) begin
            e = {USR_LOAD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, q_m};
            sb_q.push_back(e);
            q_m = data;
        end
        if (mode != 2'b00 && count != 3'd0) begin
            for (int i = 0; i < int'(count); i++) begin
                case (mode)
                    2'b01: begin
                        e   = {USR_SHR, fill, 1'b0, 1'b1, 1'b0, 1'b0, q_m};
                        q_m = {fill, q_m[3:1]};
                    end
                    2'b10: begin
                        e   = {USR_SHL, 1'b0, fill, 1'b1, 1'b0, 1'b0, q_m};
                        q_m = {q_m[2:0], fill};
                    end
                    default: begin
                        e   = {USR_SHR, q_m[0], 1'b0, 1'b1, 1'b0, 1'b0, q_m};
                        q_m = {q_m[0], q_m[3:1]};
                    end
                endcase
                sb_q.push_back(e);
            end
        end
        e = {USR_HOLD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, q_m};
        sb_q.push_back(e);
        e = {USR_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, q_m};
        sb_q.push_back(e);
    endfunction

    // Called on a falling edge with the DUT idle; offers one command for one cycle.
    task automatic issue(input logic load, input logic [1:0] mode, input logic fill,
                         input logic [3:0] data, input logic [2:0] count);
        cmd_if.cmd_load  = load;
        cmd_if.cmd_mode  = mode;
        cmd_if.cmd_fill  = fill;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_count = count;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        push_cmd(load, mode, fill, data, count);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Pops one expectation per falling edge; junk=1 keeps offering a different command while busy.
    task automatic drain(input string tag, input bit junk, input int stop_after,
                         output int busy_cyc, output int done_cyc);
        obs_t exp_o, got_o;
        int   popped = 0;
        busy_cyc = 0;
        done_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            exp_o = sb_q.pop_front();
            got_o = observe();
            popped++;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL %s cycle %0d (sel,rin,lin,busy,done,ready,q): got %b,%b,%b,%b,%b,%b,%b required %b,%b,%b,%b,%b,%b,%b",
                         tag, popped, got_o.sel, got_o.rin, got_o.lin, got_o.busy, got_o.done,
                         got_o.ready, got_o.q, exp_o.sel, exp_o.rin, exp_o.lin, exp_o.busy,
                         exp_o.done, exp_o.ready, exp_o.q);
            end
            if (got_o.busy === 1'b1) busy_cyc++;
            if (got_o.done === 1'b1) done_cyc++;
            if (junk) begin
                cmd_if.cmd_load  = 1'b1;
                cmd_if.cmd_mode  = 2'b01;
                cmd_if.cmd_fill  = 1'b1;
                cmd_if.cmd_data  = 4'b1111;
                cmd_if.cmd_count = 3'd5;
                cmd_if.cmd_valid = exp_o.busy;
            end
            if (stop_after > 0 && popped == stop_after) break;
        end
        if (stop_after == 0 && sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d expectations left, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        obs_t got_o;
        obs_t rst_o;
        rst_o = {USR_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        rst = 1'b1;
        q_m = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got_o = observe();
            n_cmp++;
            if (got_o !== rst_o || b !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: got obs=%b b=%b, required obs=%b b=0000",
                         i, got_o, b, rst_o);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b busy=%b done=%b, required 1,0,0",
                     cmd_if.cmd_ready, busy, done);
        end
    endtask

    task automatic test_shr_fill();
        int bc, dc;
        issue(1'b1, 2'b01, 1'b1, 4'b0101, 3'd2);
        drain("shr_fill", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 4 || dc !== 1 || q !== 4'b1101 || b !== 4'b0101) begin
            n_err++;
            $display("FAIL shr_fill_end: got busy_cyc=%0d done=%0d q=%b b=%b, required 4 1 1101 0101",
                     bc, dc, q, b);
        end
    endtask

    task automatic test_shl();
        int bc, dc;
        issue(1'b1, 2'b10, 1'b0, 4'b0011, 3'd3);
        drain("shl", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 5 || dc !== 1 || q !== 4'b1000) begin
            n_err++;
            $display("FAIL shl_end: got busy_cyc=%0d done=%0d q=%b, required 5 1 1000", bc, dc, q);
        end
    endtask

    task automatic test_back_to_back_rotate();
        int bc, dc;
        issue(1'b1, 2'b11, 1'b1, 4'b1001, 3'd4);
        drain("rotate4", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 6 || dc !== 1 || q !== 4'b1001) begin
            n_err++;
            $display("FAIL rotate4_end: got busy_cyc=%0d done=%0d q=%b, required 6 1 1001", bc, dc, q);
        end
        issue(1'b1, 2'b11, 1'b0, 4'b1001, 3'd1);
        drain("rotate1", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 3 || dc !== 1 || q !== 4'b1100) begin
            n_err++;
            $display("FAIL rotate1_end: got busy_cyc=%0d done=%0d q=%b, required 3 1 1100", bc, dc, q);
        end
    endtask

    task automatic test_nop_ignore();
        int bc, dc;
        issue(1'b0, 2'b00, 1'b0, 4'b0110, 3'd0);
        drain("nop", 1'b1, 0, bc, dc);
        n_cmp++;
        if (bc !== 1 || dc !== 1 || q !== 4'b1100 || b !== 4'b0110) begin
            n_err++;
            $display("FAIL nop_end: got busy_cyc=%0d done=%0d q=%b b=%b, required 1 1 1100 0110",
                     bc, dc, q, b);
        end
    endtask

    task automatic test_zero_shift_cases();
        int bc, dc;
        issue(1'b1, 2'b01, 1'b1, 4'b1010, 3'd0);
        drain("load_cnt0", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 2 || q !== 4'b1010) begin
            n_err++;
            $display("FAIL load_cnt0_end: got busy_cyc=%0d q=%b, required 2 1010", bc, q);
        end
        issue(1'b0, 2'b00, 1'b1, 4'b0001, 3'd7);
        drain("mode0_cnt7", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 1 || q !== 4'b1010) begin
            n_err++;
            $display("FAIL mode0_cnt7_end: got busy_cyc=%0d q=%b, required 1 1010", bc, q);
        end
        issue(1'b0, 2'b10, 1'b1, 4'b0001, 3'd5);
        drain("shl_noload", 1'b0, 0, bc, dc);
        n_cmp++;
        if (bc !== 6 || q !== 4'b1111) begin
            n_err++;
            $display("FAIL shl_noload_end: got busy_cyc=%0d q=%b, required 6 1111", bc, q);
        end
    endtask

    task automatic test_reset_abort();
        int   bc, dc;
        obs_t got_o;
        issue(1'b1, 2'b01, 1'b0, 4'b1000, 3'd7);
        drain("abort_pre", 1'b0, 4, bc, dc);
        rst = 1'b1;
        sb_q.delete();
        q_m = 4'b0000;
        @(negedge clk);
        got_o = observe();
        n_cmp++;
        if (got_o !== {USR_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000} || b !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_in_reset: got obs=%b b=%b, required obs=00000000000 b=0000", got_o, b);
        end
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
            n_cmp++;
            if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || {s1, s0} !== USR_HOLD) begin
                n_err++;
                $display("FAIL abort_release cycle %0d: got ready=%b busy=%b sel=%b%b, required 1 0 00",
                         i, cmd_if.cmd_ready, busy, s1, s0);
            end
        end
        n_cmp++;
        if (dc !== 0) begin
            n_err++;
            $display("FAIL abort_done: got %0d done pulses, required 0", dc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, required completion");
        $fatal(1);
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_load  = 1'b0;
        cmd_if.cmd_mode  = 2'b00;
        cmd_if.cmd_fill  = 1'b0;
        cmd_if.cmd_data  = 4'b0000;
        cmd_if.cmd_count = 3'd0;
        test_reset();
        test_shr_fill();
        test_shl();
        test_back_to_back_rotate();
        test_nop_ignore();
        test_zero_shift_cases();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usr_seq.md
USR_SEQ -- requirements
Module: usr_seq

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the shift-register data width.
REQ-002 Parameter CNT_W, default 3, SHALL set the shift-count field width (0..2^CNT_W-1 shifts).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL signal that a command is offered.
REQ-006 cmd_ready  output  1  SHALL signal that a command can be accepted.
REQ-007 cmd_load  input  1  SHALL request a parallel load of cmd_data before shifting.
REQ-008 cmd_mode  input  2  SHALL select the shift type: 00 none, 01 shift right with fill, 10 shift left with fill, 11 rotate right.
REQ-009 cmd_fill  input  1  SHALL be the serial bit shifted in for modes 01 and 10.
REQ-010 cmd_data  input  WIDTH  SHALL be the parallel-load value.
REQ-011 cmd_count  input  CNT_W  SHALL be the number of shift cycles.
REQ-012 q_fb  input  WIDTH  SHALL be the q output of the controlled usr instance.
REQ-013 s1, s0  output  1 each  SHALL be the usr mode select: 00 hold, 01 shift right (r_in enters MSB), 10 shift left (l_in enters LSB), 11 parallel load.
REQ-014 b  output  WIDTH  SHALL be the usr parallel-load data.
REQ-015 r_in, l_in  output  1 each  SHALL be the usr right and left serial inputs.
REQ-016 busy  output  1  SHALL be high while a command is in progress.
REQ-017 done  output  1  SHALL pulse high for exactly one cycle when a command completes.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1, capturing all cmd_* fields.
REQ-020 From IDLE, acceptance SHALL move to LOAD if cmd_load=1; otherwise to SHIFT if count>0 and mode!=00; otherwise to DONE.
REQ-021 LOAD SHALL last 1 cycle with s1s0=11 and b=captured data, then go to SHIFT if count>0 and mode!=00, else DONE.
REQ-022 SHIFT SHALL last exactly count cycles using an internal down-counter, then go to DONE.
REQ-023 In SHIFT, mode 01 SHALL drive s1s0=01 with r_in=fill; mode 10 SHALL drive s1s0=10 with l_in=fill; mode 11 SHALL drive s1s0=01 with r_in=q_fb[0], combinationally.
REQ-024 In every state except LOAD and SHIFT, s1s0 SHALL be 00; r_in and l_in SHALL be 0 whenever they are not selected for shifting.
REQ-025 b SHALL hold the last captured cmd_data between commands.
REQ-026 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 cmd_valid while busy SHALL be ignored, and the captured fields SHALL NOT change.
REQ-029 Outputs SHALL NOT depend combinationally on cmd_* inputs; only r_in in mode 11 depends on q_fb.
REQ-030 Total busy cycles SHALL equal cmd_load + (mode!=00 ? count : 0) + 1.

Reset
REQ-031 While rst=1, the block SHALL go to IDLE and drive s1s0=00, b=0, r_in=0, l_in=0, busy=0, done=0, cmd_ready=0.
REQ-032 Reset asserted mid-command SHALL abort the command with no done pulse; cmd_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-033 Package usr_pkg SHALL hold the FSM state enum, the cmd_mode encodings and the usr select constants USR_HOLD=00, USR_SHR=01, USR_SHL=10, USR_LOAD=11.
REQ-034 usr_seq SHALL contain no sub-module; it drives an external usr instance, and the bench SHALL instantiate both.

Verification (WIDTH=4, usr_seq connected to usr)
REQ-035 Scenario: rst=1 for 2 cycles, then released -> during reset s1s0=00, b=0000, busy=0, done=0, cmd_ready=0; cmd_ready=1 on the first cycle after release.
REQ-036 Scenario: load=1, mode=01, fill=1, data=0101, count=2 -> 1 cycle s1s0=11, 2 cycles s1s0=01 with r_in=1, done after 4 busy cycles, q=1101.
REQ-037 Scenario: load=1, mode=10, fill=0, data=0011, count=3 -> q goes 0011, 0110, 1100, 1000; done after 5 busy cycles.
REQ-038 Scenario: load=1, mode=11, data=1001, count=4 -> r_in follows q[0] each cycle, final q=1001; with count=1, final q=1100.
REQ-039 Scenario: load=0, mode=00, count=0 -> 1 busy cycle, s1s0 stays 00, q unchanged, done pulses once; a cmd_valid offered during that cycle is not accepted.
REQ-040 Scenario: load=1, mode=01, count=7, rst asserted on the 3rd shift cycle -> next cycle s1s0=00, busy=0, no done pulse; cmd_ready=1 after rst deasserts.
